// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers, bounded bursts per grant.
// Latency: valid seen in IDLE at edge N -> owner at N+1 -> first write in the cycle after N+1; one idle cycle between grants.
// Backpressure: fifo_full drops the owner's ready and the write strobe combinationally; grant and beat count hold while full.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_write,
    output logic [WIDTH-1:0]      fifo_data,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [7:0]       beat_cnt;

    logic [WIDTH-1:0] data_arr [NREQ];

    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    logic              pick_vld;
    logic [IDW-1:0]    pick_off;
    logic [IDW:0]      pick_sum;
    logic [IDW-1:0]    pick_id;

    logic              own_valid;
    logic              own_last;
    logic              xfer;
    logic              burst_done;
    logic              release_now;
    logic [IDW:0]      next_sum;
    logic [IDW-1:0]    next_ptr;

    // Flat data bus split per requester so the owner's slice is a plain lookup.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Rotate valids so bit 0 sits at rr_ptr; the lowest set bit of the rotation is the next owner.
    always_comb begin
        valid_dbl = {req_valid, req_valid} >> rr_ptr;
        valid_rot = valid_dbl[NREQ-1:0];
        pick_vld  = |valid_rot;
        pick_off  = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                pick_off = IDW'(j);
            end
        end
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= (IDW+1)'(NREQ)) begin
            pick_sum = pick_sum - (IDW+1)'(NREQ);
        end
        pick_id = pick_sum[IDW-1:0];
    end

    // Owner handshake, release decision and the pointer that follows the current owner.
    always_comb begin
        own_valid  = req_valid[grant_id];
        own_last   = req_last[grant_id];
        xfer       = (state == ST_GRANT) && rst_n && own_valid && !fifo_full;
        burst_done = (beat_cnt + 8'd1) == 8'(BURST);
        // Owner going idle only counts while the FIFO can accept; a full FIFO freezes the grant.
        release_now = (state == ST_GRANT) &&
                      ((xfer && (own_last || burst_done)) || (!fifo_full && !own_valid));
        next_sum = {1'b0, grant_id} + (IDW+1)'(1);
        if (next_sum >= (IDW+1)'(NREQ)) begin
            next_sum = '0;
        end
        next_ptr = next_sum[IDW-1:0];
    end

    // Write-port outputs track the owner combinationally; reset low suppresses any further write at once.
    always_comb begin
        req_ready  = '0;
        fifo_write = 1'b0;
        fifo_data  = '0;
        if ((state == ST_GRANT) && rst_n) begin
            req_ready[grant_id] = !fifo_full;
            fifo_write          = xfer;
            fifo_data           = data_arr[grant_id];
        end
    end

    // Arbitration FSM: pick an owner in IDLE, count beats and release in GRANT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= ST_GRANT;
                        busy     <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (release_now) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queued producers, transaction-level reference model, per-cycle output compare.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
// Directed scenarios check the captured write log against hand-computed sequences.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_write;
    logic [WIDTH-1:0]      fifo_data;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Producer beat storage: {last, data} per requester
    logic [8:0] mem [NREQ][64];
    int head [NREQ];
    int tail [NREQ];
    logic [NREQ-1:0] acc = '0;

    // Reference model state: owner -1 means no grant
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_gid   = 0;
    int m_nw    = 0;

    // Captured DUT writes
    int log_id  [256];
    int log_dat [256];
    int log_cyc [256];
    int n_log = 0;
    int stall_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [WIDTH-1:0] slice_of(input logic [NREQ*WIDTH-1:0] d, input int i);
        logic [NREQ*WIDTH-1:0] t;
        t = d >> (i * WIDTH);
        return t[WIDTH-1:0];
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] != tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input int dat, input bit last);
        mem[i][tail[i]] = {last, 8'(dat)};
        tail[i]++;
    endtask

    // Producer: handshake sampled on the falling edge, next beat presented just after the rising edge
    always @(negedge clk) begin
        acc = req_valid & req_ready;
    end

    always @(posedge clk) begin
        logic [NREQ-1:0]       nv;
        logic [NREQ-1:0]       nl;
        logic [NREQ*WIDTH-1:0] nd;
        #1;
        nv = '0;
        nl = '0;
        nd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bit_of(acc, i)) head[i]++;
            if (head[i] < tail[i]) begin
                nv = nv | (NREQ'(1) << i);
                if (mem[i][head[i]][8]) nl = nl | (NREQ'(1) << i);
                nd = nd | ((NREQ*WIDTH)'(mem[i][head[i]][7:0]) << (i * WIDTH));
            end
        end
        req_valid = nv;
        req_last  = nl;
        req_data  = nd;
    end

    // Reference model: grant/release rules applied at each rising edge
    always @(posedge clk) begin
        bit found;
        cyc++;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
            m_gid   = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && bit_of(req_valid, (m_ptr + k) % NREQ)) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % NREQ;
                    m_gid   = m_owner;
                    m_beats = 0;
                end
            end
        end else if (!fifo_full) begin
            if (bit_of(req_valid, m_owner)) begin
                m_beats++;
                m_nw++;
                if (bit_of(req_last, m_owner) || m_beats == BURST) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end else begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    end

    // Per-cycle compare against the model, plus write log and stall monitor
    always @(negedge clk) begin
        logic [NREQ-1:0]  e_ready;
        logic             e_write;
        logic [WIDTH-1:0] e_data;
        e_ready = '0;
        e_write = 1'b0;
        e_data  = '0;
        if (rst_n && m_owner >= 0) begin
            e_ready = fifo_full ? '0 : (NREQ'(1) << m_owner);
            e_write = bit_of(req_valid, m_owner) && !fifo_full;
            e_data  = slice_of(req_data, m_owner);
        end
        chk("cyc_req_ready", 32'(req_ready), 32'(e_ready));
        chk("cyc_fifo_write", 32'(fifo_write), 32'(e_write));
        chk("cyc_fifo_data", 32'(fifo_data), 32'(e_data));
        chk("cyc_grant_id", 32'(grant_id), 32'(m_gid));
        chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
        if (fifo_write === 1'b1 && n_log < 256) begin
            log_id[n_log]  = int'(grant_id);
            log_dat[n_log] = int'(fifo_data);
            log_cyc[n_log] = cyc;
            n_log++;
        end
        if (busy === 1'b1 && fifo_full && req_ready === '0 && fifo_write === 1'b0) stall_cnt++;
    end

    task automatic exp_w(input string nm, input int idx, input int id, input int dat);
        chk($sformatf("%s[%0d].id", nm, idx), 32'(log_id[idx]), 32'(id));
        chk($sformatf("%s[%0d].data", nm, idx), 32'(log_dat[idx]), 32'(dat));
    endtask

    task automatic wait_done(input string nm);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < 500) begin
            @(posedge clk);
            #2;
            n++;
            done = queues_empty() && (m_owner < 0) && (busy === 1'b0);
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_writes(input string nm, input int target);
        int n;
        n = 0;
        while (m_nw < target && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({nm, "_writes_reached"}, 32'(m_nw >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int w0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // T1: reset held with every requester valid; first grant goes to 0
        s = n_log;
        for (int i = 0; i < NREQ; i++) push(i, 'h10 + i, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        chk("t1_rst_ready", 32'(req_ready), 32'd0);
        chk("t1_rst_write", 32'(fifo_write), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_gid", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        wait_done("t1");
        chk("t1_nwrites", 32'(n_log - s), 32'd4);
        for (int i = 0; i < NREQ; i++) exp_w("t1", s + i, i, 'h10 + i);

        // T2: single requester, three beats ending on last
        s = n_log;
        push(1, 'hA1, 1'b0);
        push(1, 'hA2, 1'b0);
        push(1, 'hA3, 1'b1);
        wait_done("t2");
        chk("t2_nwrites", 32'(n_log - s), 32'd3);
        exp_w("t2", s + 0, 1, 'hA1);
        exp_w("t2", s + 1, 1, 'hA2);
        exp_w("t2", s + 2, 1, 'hA3);
        chk("t2_back_to_back", 32'(log_cyc[s + 2] - log_cyc[s]), 32'd2);

        // T2b: pointer now 2, so requester 2 beats requester 0
        s = n_log;
        push(0, 'hB0, 1'b1);
        push(2, 'hB2, 1'b1);
        wait_done("t2b");
        chk("t2b_nwrites", 32'(n_log - s), 32'd2);
        exp_w("t2b", s + 0, 2, 'hB2);
        exp_w("t2b", s + 1, 0, 'hB0);

        // T3: reset pulse, then all four stream 8 beats without last
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        s = n_log;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 8; k++) push(i, i * 16 + k, 1'b0);
        end
        wait_done("t3");
        chk("t3_nwrites", 32'(n_log - s), 32'd32);
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) begin
                exp_w("t3", s + g * 4 + k, g % 4, (g % 4) * 16 + (g / 4) * 4 + k);
            end
        end
        chk("t3_span_cycles", 32'(log_cyc[s + 31] - log_cyc[s] + 1), 32'd39);

        // T4: FIFO full for three cycles after beat 2 of requester 2
        s = n_log;
        stall_cnt = 0;
        w0 = m_nw;
        for (int k = 0; k < 4; k++) push(2, 'hC0 + k, 1'b0);
        wait_writes("t4", w0 + 2);
        fifo_full = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        fifo_full = 1'b0;
        wait_done("t4");
        chk("t4_nwrites", 32'(n_log - s), 32'd4);
        for (int k = 0; k < 4; k++) exp_w("t4", s + k, 2, 'hC0 + k);
        chk("t4_stall_cycles", 32'(stall_cnt), 32'd3);

        // T5: owner 3 drops valid after one beat; pointer wraps to 0
        s = n_log;
        push(3, 'hD3, 1'b0);
        push(0, 'hE0, 1'b1);
        push(1, 'hE1, 1'b1);
        wait_done("t5");
        chk("t5_nwrites", 32'(n_log - s), 32'd3);
        exp_w("t5", s + 0, 3, 'hD3);
        exp_w("t5", s + 1, 0, 'hE0);
        exp_w("t5", s + 2, 1, 'hE1);

        // T6: reset after beat 2 of a grant to requester 1
        s = n_log;
        w0 = m_nw;
        for (int k = 0; k < 4; k++) push(1, 'hF0 + k, 1'b0);
        wait_writes("t6", w0 + 2);
        rst_n = 1'b0;
        push(0, 'h90, 1'b1);
        push(2, 'h92, 1'b1);
        @(posedge clk);
        #2;
        chk("t6_busy_after_rst", 32'(busy), 32'd0);
        chk("t6_write_in_rst", 32'(fifo_write), 32'd0);
        chk("t6_nwrites_at_rst", 32'(n_log - s), 32'd2);
        rst_n = 1'b1;
        wait_done("t6");
        chk("t6_nwrites", 32'(n_log - s), 32'd6);
        exp_w("t6", s + 0, 1, 'hF0);
        exp_w("t6", s + 1, 1, 'hF1);
        exp_w("t6", s + 2, 0, 'h90);
        exp_w("t6", s + 3, 1, 'hF2);
        exp_w("t6", s + 4, 1, 'hF3);
        exp_w("t6", s + 5, 2, 'h92);

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port among NREQ producers.
- Each producer presents a valid/ready stream. The arbiter grants one owner at a time for a bounded burst and steers that owner's data onto the FIFO write port.
- It honours the FIFO full flag and also reports which source is writing.
- Sits directly in front of the FIFO write side.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, data width, matches FIFO WIDTH
- BURST, 4, maximum beats per grant before forced release (1..255)
- IDW, 2, width of the source id, equal to clog2(NREQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NREQ  per-requester data valid
- req_data  in  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  in  NREQ  marks final beat of a requester's packet
- req_ready  out  NREQ  per-requester accept
- fifo_full  in  1  full flag from the FIFO
- fifo_write  out  1  FIFO write strobe
- fifo_data  out  WIDTH  FIFO write data
- grant_id  out  IDW  current owner index
- busy  out  1  high while in GRANT

Interface rule: reset rst_n is synchronous, active-low; clock is clk.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
  - Outputs: req_ready=0, fifo_write=0, fifo_data=0, busy=0.
  - Reset mid-burst aborts the grant with no further writes.
- State machine: two states, IDLE and GRANT.
- IDLE:
  - req_ready all 0, fifo_write=0, fifo_data=0, busy=0.
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Register it into grant_id, clear beat_cnt, go to GRANT on the next edge.
  - No valid: stay in IDLE.
- GRANT:
  - busy=1.
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - fifo_data = req_data slice of grant_id, combinational.
  - fifo_write = req_valid[grant_id] & !fifo_full. This is a "transfer"; it is combinational so the FIFO never writes when full.
  - On a transfer, beat_cnt increments.
- Release conditions, any one of which sends the arbiter to IDLE on the next edge with rr_ptr = (grant_id+1) mod NREQ:
  - (a) transfer with req_last[grant_id]=1.
  - (b) transfer that makes beat_cnt reach BURST.
  - (c) req_valid[grant_id]=0 while fifo_full=0. The owner went idle; no transfer happens that cycle.
- fifo_full in GRANT:
  - Stall: no transfer, beat_cnt holds, grant holds regardless of owner valid.
  - Condition (c) is not evaluated while full.
- Latency and throughput:
  - Valid seen in IDLE at edge N gives grant at N+1 and a first write in the cycle after edge N+1 if not full.
  - One mandatory IDLE arbitration cycle between grants; peak throughput is BURST/(BURST+1).
- Fairness:
  - A requester that is continuously valid is granted within NREQ-1 intervening grants.
  - Starvation-free.
- Non-owner valids are ignored during GRANT and must be held by the producers (ready=0).
- beat_cnt is 8 bits and saturation is impossible: release at BURST.
- Simultaneous last and BURST reached on the same beat counts as a single release.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with all req_valid=1 -> req_ready=0, fifo_write=0, busy=0, grant_id=0; first grant after release goes to requester 0.
- Single requester: req1 sends 3 beats 0xA1,0xA2,0xA3 with last on 0xA3, FIFO not full -> grant_id=1, three consecutive fifo_write with those data, then IDLE, rr_ptr=2.
- Round robin: all 4 valid continuously, no last, BURST=4 -> grant order 0,1,2,3,0, each with exactly 4 writes separated by one idle cycle.
- Backpressure: req2 streaming, fifo_full=1 for 3 cycles after beat 2 -> fifo_write=0 and req_ready[2]=0 during the stall; beats 3..4 resume, exactly 4 total writes, no data lost or duplicated.
- Owner drop: req3 granted, sends 1 beat, then req_valid[3]=0 -> release after 1 write; next grant goes to requester 0 if valid.
- Reset mid-burst: assert rst_n=0 after beat 2 of a grant to requester 1 -> no further writes, busy=0 next edge, next arbitration starts from rr_ptr=0.
